// File: rtl/pwm_multichannel_if.sv
// Peripheral write bus into the PWM block: one shadow-register write per cycle.
// No handshake: every cycle with wr_en high is a committed write.
interface pwm_multichannel_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM, shared edge/center-aligned counter, shadowed duty/period/mode.
// Latency: writes reach active registers at the next period boundary; pwm_out lags counter by 1 cycle.
// Backpressure: none, writes are always accepted; a write on the boundary edge bypasses into active.
module pwm_multichannel #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 8,
    parameter int DEFAULT_PERIOD = 100,
    parameter int ADDR_W         = 5
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              enable,
    pwm_multichannel_if.slave wr,
    output logic [N_CH-1:0]   pwm_out,
    output logic [CNT_W-1:0]  counter,
    output logic              period_end
);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t ONE     = cnt_t'(1);
    localparam cnt_t PER_RST = cnt_t'(DEFAULT_PERIOD);

    cnt_t duty_sh  [N_CH];
    cnt_t duty_act [N_CH];
    cnt_t duty_nx  [N_CH];
    cnt_t per_sh, per_act, per_nx;
    logic mode_sh, mode_act, mode_nx;
    logic dir_down;

    cnt_t cnt_nxt;
    logic dir_nxt, run, boundary, load;

    // Shadow values after this cycle's write; also what active takes on a load.
    always_comb begin
        per_nx  = per_sh;
        mode_nx = mode_sh;
        for (int i = 0; i < N_CH; i++) begin
            duty_nx[i] = duty_sh[i];
            if (wr.wr_en && wr.wr_addr == ADDR_W'(i))
                duty_nx[i] = wr.wr_data;
        end
        if (wr.wr_en && wr.wr_addr == ADDR_W'(N_CH))
            per_nx = wr.wr_data;
        if (wr.wr_en && wr.wr_addr == ADDR_W'(N_CH + 1))
            mode_nx = wr.wr_data[0];
    end

    always_comb begin
        run     = enable && (per_act != '0);
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        if (run) begin
            if (mode_act) begin
                cnt_nxt = (dir_down || counter >= per_act) ? counter - ONE : counter + ONE;
                // Stay down until the count returns to zero, which is the boundary.
                dir_nxt = (cnt_nxt != '0) && (dir_down || counter >= per_act);
            end else begin
                cnt_nxt = (counter >= per_act) ? '0 : counter + ONE;
            end
        end
        boundary = run && (cnt_nxt == '0);
        load     = !run || boundary;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            counter    <= '0;
            dir_down   <= 1'b0;
            per_sh     <= PER_RST;
            per_act    <= PER_RST;
            mode_sh    <= 1'b0;
            mode_act   <= 1'b0;
            pwm_out    <= '0;
            period_end <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            counter    <= cnt_nxt;
            dir_down   <= dir_nxt;
            period_end <= boundary;
            per_sh     <= per_nx;
            mode_sh    <= mode_nx;
            if (load) begin
                per_act  <= per_nx;
                mode_act <= mode_nx;
            end
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i] <= duty_nx[i];
                if (load)
                    duty_act[i] <= duty_nx[i];
                pwm_out[i] <= run && (counter < duty_act[i]);
            end
        end
    end
endmodule
